iterative_divider: RTL and testbench

Sequential radix-2 restoring divider: the inverse companion to the pipelined Booth multiplier in the same arithmetic unit. It accepts one dividend/divisor pair per transaction over a valid/ready handshake and iterates one quotient bit per cycle. It returns quotient and remainder with RISC-V M-extension semantics for signed and unsigned division, including divide-by-zero and overflow. It sits beside the multiplier in the execute stage and shares its operand buses.

---
 rtl/iterative_divider_if.sv | 40 ++++
 rtl/iterative_divider.sv | 153 +++++++++++++++
 tb/tb_iterative_divider.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/iterative_divider_if.sv
// ---------------------------------------------------------------------------
// iterative_divider_if
// Operand/result bundle between the execute stage and the iterative divider.
//
// Signals:
//   in_valid / in_ready    request handshake (requester -> divider)
//   dividend, divisor      operands, WIDTH bits
//   is_signed              1 = two's-complement operands, 0 = unsigned
//   out_valid / out_ready  result handshake (divider -> consumer)
//   quotient, remainder    registered results, WIDTH bits
//   busy                   divider is working on or holding a result
//
// Modports:
//   slave  - divider side
//   master - requester/consumer side
// ---------------------------------------------------------------------------
interface iterative_divider_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;

  modport slave (
    input  in_valid, dividend, divisor, is_signed, out_ready,
    output in_ready, out_valid, quotient, remainder, busy
  );

  modport master (
    output in_valid, dividend, divisor, is_signed, out_ready,
    input  in_ready, out_valid, quotient, remainder, busy
  );
endinterface

// File: rtl/iterative_divider.sv
// ---------------------------------------------------------------------------
// iterative_divider
// Sequential radix-2 restoring divider with RISC-V M-extension semantics
// (DIV/DIVU/REM/REMU), producing one quotient bit per clock.
//
// Ports:
//   clk   clock, all state changes on the rising edge
//   rst   asynchronous, active-high reset
//   bus   iterative_divider_if.slave: operand handshake (in_valid/in_ready,
//         dividend, divisor, is_signed), result handshake (out_valid/
//         out_ready, quotient, remainder) and busy status
//
// Flow: IDLE -> CALC (WIDTH iterations) -> FIX (apply signs) -> DONE.
// Divide-by-zero and signed overflow skip CALC and produce their fixed
// results with a one-cycle latency.
// ---------------------------------------------------------------------------
module iterative_divider #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  iterative_divider_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic [CNT_W-1:0] count;
  logic             neg_q;
  logic             neg_r;
  logic             special;

  logic             accept;
  logic             div_by_zero;
  logic             overflow;
  logic [WIDTH-1:0] dividend_mag_in;
  logic [WIDTH-1:0] divisor_mag_in;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;

  // Accept decode and special-case detection look at the raw operands on
  // the bus; they only matter on the accepting edge.
  assign accept      = bus.in_valid && (state == S_IDLE);
  assign div_by_zero = (bus.divisor == '0);
  assign overflow    = bus.is_signed && (bus.dividend == MIN_NEG) &&
                       (bus.divisor == '1);

  // Magnitudes of the incoming operands. The most negative value maps onto
  // itself, which is still the correct unsigned magnitude.
  assign dividend_mag_in = (bus.is_signed && bus.dividend[WIDTH-1]) ?
                           -bus.dividend : bus.dividend;
  assign divisor_mag_in  = (bus.is_signed && bus.divisor[WIDTH-1]) ?
                           -bus.divisor : bus.divisor;

  // One restoring step. The stored remainder is always below the divisor
  // magnitude, so it fits in WIDTH bits; only the shifted trial value needs
  // the extra bit, whose borrow tells us whether the subtraction went
  // negative.
  assign rem_shift = {rem, dvd[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, divisor_mag};

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;

  // Main controller and datapath. The dividend register doubles as the
  // quotient register: each iteration shifts one dividend bit out of the top
  // and one quotient bit into the bottom. Special cases load their results
  // at accept and pass through FIX untouched, so they appear one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rem         <= '0;
      dvd         <= '0;
      divisor_mag <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      count       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      special     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (div_by_zero || overflow) begin
              quotient_q  <= div_by_zero ? '1 : MIN_NEG;
              remainder_q <= div_by_zero ? bus.dividend : '0;
              special     <= 1'b1;
              state       <= S_FIX;
            end else begin
              dvd         <= dividend_mag_in;
              divisor_mag <= divisor_mag_in;
              neg_q       <= bus.is_signed &&
                             (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
              neg_r       <= bus.is_signed && bus.dividend[WIDTH-1];
              rem         <= '0;
              count       <= '0;
              special     <= 1'b0;
              state       <= S_CALC;
            end
          end
        end

        S_CALC: begin
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_shift[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], 1'b0};
          end
          count <= count + 1'b1;
          if (count == LAST_ITER) begin
            state <= S_FIX;
          end
        end

        S_FIX: begin
          if (!special) begin
            quotient_q  <= neg_q ? -dvd : dvd;
            remainder_q <= neg_r ? -rem : rem;
          end
          state <= S_DONE;
        end

        S_DONE: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// ---------------------------------------------------------------------------
// tb_iterative_divider
// Self-checking bench for iterative_divider. Directed operand pairs are
// driven through the interface; a monitor keeps an arithmetic model of each
// accepted request and checks results, latency and handshake status on every
// cycle a result is pending. Hand-computed literals pin the model.
// ---------------------------------------------------------------------------
module tb_iterative_divider;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst;

  int checks     = 0;
  int errors     = 0;
  int cycleCount = 0;

  iterative_divider_if #(.WIDTH(WIDTH)) bus ();

  iterative_divider #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Edge counter used to measure accept-to-result latency.
  always @(posedge clk) cycleCount++;

  // Single comparison point: every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual,
               expected);
    end
  endtask

  // Reference division from the arithmetic rules: fixed results for the two
  // special cases, native truncating division otherwise.
  function automatic logic [63:0] modelDivide(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic s);
    longint sa, sb, q, r;
    if (b == 32'h0) return {32'hFFFFFFFF, a};
    if (s && a == 32'h80000000 && b == 32'hFFFFFFFF)
      return {32'h80000000, 32'h0};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {q[31:0], r[31:0]};
    end
    return {a / b, a % b};
  endfunction

  function automatic int modelLatency(input logic [31:0] a,
                                      input logic [31:0] b,
                                      input logic s);
    if (b == 32'h0) return 1;
    if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return WIDTH + 1;
  endfunction

  // Monitor/scoreboard: records the model result on each accept and checks
  // the DUT on every falling edge while that request is outstanding.
  logic [31:0] expQ, expR;
  logic [63:0] modelRes;
  int          expLat;
  int          acceptCycle;
  bit          havePending  = 1'b0;
  bit          expectReady  = 1'b0;
  bit          prevOutValid = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      havePending  = 1'b0;
      expectReady  = 1'b0;
      prevOutValid = 1'b0;
    end else begin
      if (expectReady) begin
        checkOutput("readyAfterHandoff", {31'b0, bus.in_ready}, 32'd1);
        expectReady = 1'b0;
      end
      if (havePending) begin
        if (bus.out_valid) begin
          if (!prevOutValid)
            checkOutput("latency", 32'(cycleCount - acceptCycle), 32'(expLat));
          checkOutput("quotient", bus.quotient, expQ);
          checkOutput("remainder", bus.remainder, expR);
          checkOutput("doneBusyReady", {30'b0, bus.busy, bus.in_ready}, 32'd2);
          if (bus.out_ready) begin
            havePending = 1'b0;
            expectReady = 1'b1;
          end
        end else begin
          checkOutput("workingBusyReady", {30'b0, bus.busy, bus.in_ready},
                      32'd2);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        modelRes    = modelDivide(bus.dividend, bus.divisor, bus.is_signed);
        expQ        = modelRes[63:32];
        expR        = modelRes[31:0];
        expLat      = modelLatency(bus.dividend, bus.divisor, bus.is_signed);
        acceptCycle = cycleCount + 1;
        havePending = 1'b1;
      end
      prevOutValid = bus.out_valid;
    end
  end

  // Drives one request, optionally pokes in_valid during CALC, waits for the
  // result, holds back-pressure for holdCycles, checks the literal answer,
  // then hands the result off. Entered and left just after a rising edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic s, input int holdCycles,
                               input bit pokeDuringCalc,
                               input logic [31:0] litQ,
                               input logic [31:0] litR);
    int waitCount;
    waitCount = 0;
    while (!bus.in_ready && waitCount < 50) begin
      @(posedge clk); #1;
      waitCount++;
    end
    if (!bus.in_ready) begin
      checkOutput("acceptTimeout", 32'd0, 32'd1);
      return;
    end
    bus.dividend  = a;
    bus.divisor   = b;
    bus.is_signed = s;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.dividend = ~a;
    bus.divisor  = b ^ 32'h5A5A_0001;
    if (pokeDuringCalc) begin
      bus.in_valid  = 1'b1;
      bus.is_signed = ~s;
      repeat (3) begin
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
    end
    waitCount = 0;
    while (!bus.out_valid && waitCount < 100) begin
      @(posedge clk); #1;
      waitCount++;
    end
    if (!bus.out_valid) begin
      checkOutput("resultTimeout", 32'd0, 32'd1);
      return;
    end
    repeat (holdCycles) begin
      @(posedge clk); #1;
    end
    checkOutput("literalQuotient", bus.quotient, litQ);
    checkOutput("literalRemainder", bus.remainder, litR);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.is_signed = 1'b0;
    #12;
    checkOutput("resetInReady", {31'b0, bus.in_ready}, 32'd1);
    checkOutput("resetOutValid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("resetBusy", {31'b0, bus.busy}, 32'd0);
    checkOutput("resetQuotient", bus.quotient, 32'd0);
    checkOutput("resetRemainder", bus.remainder, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed arithmetic vectors");
    applyStimulus(32'd100, 32'd7, 1'b0, 0, 1'b0, 32'd14, 32'd2);
    applyStimulus(32'hFFFFFF9C, 32'd7, 1'b1, 0, 1'b0,
                  32'hFFFFFFF2, 32'hFFFFFFFE);
    applyStimulus(32'h12345678, 32'd0, 1'b0, 0, 1'b0,
                  32'hFFFFFFFF, 32'h12345678);
    applyStimulus(32'h12345678, 32'd0, 1'b1, 0, 1'b0,
                  32'hFFFFFFFF, 32'h12345678);
    applyStimulus(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 1'b0,
                  32'h80000000, 32'h0);
    applyStimulus(32'h80000000, 32'hFFFFFFFF, 1'b0, 0, 1'b0,
                  32'h0, 32'h80000000);
    applyStimulus(32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 0, 1'b0,
                  32'd3, 32'hFFFFFFFF);

    $display("[TB] back-pressure and busy request");
    applyStimulus(32'd1000, 32'hFFFFFFFD, 1'b1, 10, 1'b1,
                  32'hFFFFFEB3, 32'd1);

    $display("[TB] reset during CALC");
    bus.dividend  = 32'hDEADBEEF;
    bus.divisor   = 32'd3;
    bus.is_signed = 1'b0;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checkOutput("midResetInReady", {31'b0, bus.in_ready}, 32'd1);
    checkOutput("midResetOutValid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("midResetBusy", {31'b0, bus.busy}, 32'd0);
    checkOutput("midResetQuotient", bus.quotient, 32'd0);
    checkOutput("midResetRemainder", bus.remainder, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(32'hFFFFFFFF, 32'h10, 1'b0, 0, 1'b0,
                  32'h0FFFFFFF, 32'hF);

    repeat (3) begin
      @(posedge clk); #1;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Last-resort guard so a stuck run still terminates with a visible report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
